uart_tx_sequencer: RTL and testbench

//  Frame controller for the UART transmit path. Accepts a parallel word on a

---
 rtl/uart_tx_sequencer_pkg.sv | 16 +
 rtl/uart_tx_sequencer_if.sv | 13 +
 rtl/uart_tx_sequencer_bit_timer.sv | 27 ++
 rtl/uart_tx_sequencer.sv | 134 +++++++++++++
 tb/tb_uart_tx_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sequencer_pkg.sv
// uart_tx_sequencer_pkg: shared state encoding and parity mode constants for the UART TX path
package uart_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: host-side valid/ready word handshake into the TX sequencer
interface uart_tx_sequencer_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_sequencer_bit_timer.sv
// uart_tx_sequencer_bit_timer: counts oversample ticks and strobes the last tick of each bit period
module uart_tx_sequencer_bit_timer #(
    parameter int SAMPLE_RATE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clock_tick,
    output logic bit_end
);

    localparam int W = $clog2(SAMPLE_RATE);
    localparam logic [W-1:0] LAST = W'(SAMPLE_RATE - 1);

    logic [W-1:0] cnt;

    assign bit_end = run && clock_tick && cnt == LAST;

    // tick counter held at zero while stopped so every frame starts a fresh bit period
    always_ff @(posedge clk) begin
        if (rst || !run)
            cnt <= '0;
        else if (clock_tick)
            cnt <= bit_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: UART transmit frame controller driving the baud generator and serial line
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_tx_sequencer_if.slave        host,
    input  logic                      clock_tick,
    output logic                      baud_enable,
    output logic                      baud_clear_n,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shift_r, shift_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_n;
    logic                 par_r, par_n;
    logic                 tx_n, done_n;
    logic                 bit_end;
    logic                 accept;

    assign busy         = state != S_IDLE;
    assign baud_enable  = busy;
    assign baud_clear_n = busy;
    assign host.tx_ready = state == S_IDLE;
    assign accept       = host.tx_valid && host.tx_ready;

    uart_tx_sequencer_bit_timer #(
        .SAMPLE_RATE(SAMPLE_RATE)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (busy),
        .clock_tick (clock_tick),
        .bit_end    (bit_end)
    );

    // frame sequencing: next state, shift data and the registered line level for the next cycle
    always_comb begin
        state_n   = state;
        shift_n   = shift_r;
        bit_cnt_n = bit_cnt;
        stop_n    = stop_cnt;
        par_n     = par_r;
        tx_n      = tx;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n   = S_START;
                    shift_n   = host.tx_data;
                    par_n     = (PARITY == PARITY_ODD) ? ~^host.tx_data : ^host.tx_data;
                    bit_cnt_n = '0;
                    stop_n    = 1'b0;
                    tx_n      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    tx_n    = shift_r[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_n = shift_r >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                        tx_n      = (PARITY != PARITY_NONE) ? par_r : 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shift_r[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tx_n = 1'b1;
                    if (stop_cnt == LAST_STOP) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    // state and datapath registers; reset aborts any frame and returns the line to idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shift_r  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_r    <= 1'b0;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            shift_r  <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_n;
            par_r    <= par_n;
            tx       <= tx_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed frame checks over four parity/stop configurations with a 4-cycle tick stub
module tb_uart_tx_sequencer;

    localparam int BIT_CYC = 64;

    logic       clk;
    logic       rst;
    logic [7:0] data_a  [4];
    logic       valid_a [4];
    logic       ready_a [4];
    logic       tx_a    [4];
    logic       busy_a  [4];
    logic       done_a  [4];
    logic       en_a    [4];
    logic       clrn_a  [4];
    logic       tick_a  [4];
    logic       xtick_a [4];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : u
        uart_tx_sequencer_if #(.DATA_BITS(8)) bus ();
        logic [1:0] sc;
        assign bus.tx_data  = data_a[g];
        assign bus.tx_valid = valid_a[g];
        assign ready_a[g]   = bus.tx_ready;
        assign tick_a[g]    = (en_a[g] && sc == 2'd3) || xtick_a[g];
        always_ff @(posedge clk)
            sc <= (rst || !clrn_a[g]) ? 2'd0 : (en_a[g] ? sc + 2'd1 : sc);
        uart_tx_sequencer #(
            .DATA_BITS   (8),
            .SAMPLE_RATE (16),
            .PARITY      (g == 1 ? 1 : (g == 2 ? 2 : 0)),
            .STOP_BITS   (g == 3 ? 2 : 1)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .host         (bus),
            .clock_tick   (tick_a[g]),
            .baud_enable  (en_a[g]),
            .baud_clear_n (clrn_a[g]),
            .tx           (tx_a[g]),
            .busy         (busy_a[g]),
            .done         (done_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input int g, input logic [7:0] d);
        data_a[g]  = d;
        valid_a[g] = 1'b1;
        @(negedge clk);
        valid_a[g] = 1'b0;
    endtask

    // entered at cycle 0 of the start bit; returns at the negedge of the done cycle
    task automatic check_frame(input int g, input logic [7:0] d, input int par, input int stops);
        logic [11:0] bits;
        int n;
        int early_done;
        logic ready_seen;
        logic idle_seen;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (par >= 0) bits[9] = par[0];
        n = 9 + (par >= 0 ? 1 : 0) + stops;
        early_done = -1;
        ready_seen = 1'b0;
        idle_seen = 1'b0;
        for (int c = 0; c < n * BIT_CYC; c++) begin
            if (c % BIT_CYC == BIT_CYC / 2)
                check($sformatf("g%0d_d%02h_bit%0d", g, d, c / BIT_CYC), tx_a[g], bits[c / BIT_CYC]);
            if (done_a[g] && early_done < 0) early_done = c;
            if (ready_a[g]) ready_seen = 1'b1;
            if (!busy_a[g] || !en_a[g] || !clrn_a[g]) idle_seen = 1'b1;
            @(negedge clk);
        end
        check($sformatf("g%0d_d%02h_early_done", g, d), early_done, -1);
        check($sformatf("g%0d_d%02h_ready_in_frame", g, d), ready_seen, 0);
        check($sformatf("g%0d_d%02h_idle_in_frame", g, d), idle_seen, 0);
        check($sformatf("g%0d_d%02h_done", g, d), done_a[g], 1);
        check($sformatf("g%0d_d%02h_ready_at_done", g, d), ready_a[g], 1);
        check($sformatf("g%0d_d%02h_busy_at_done", g, d), busy_a[g], 0);
        check($sformatf("g%0d_d%02h_tx_at_done", g, d), tx_a[g], 1);
    endtask

    initial begin
        int done_hits;
        rst = 1'b1;
        for (int g = 0; g < 4; g++) begin
            data_a[g] = 8'h00;
            valid_a[g] = 1'b0;
            xtick_a[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst_tx%0d", g), tx_a[g], 1);
            check($sformatf("rst_ready%0d", g), ready_a[g], 1);
            check($sformatf("rst_busy%0d", g), busy_a[g], 0);
            check($sformatf("rst_done%0d", g), done_a[g], 0);
            check($sformatf("rst_en%0d", g), en_a[g], 0);
            check($sformatf("rst_clrn%0d", g), clrn_a[g], 0);
        end

        start_frame(0, 8'hA5);
        check_frame(0, 8'hA5, -1, 1);
        @(negedge clk);
        check("done_one_cycle", done_a[0], 0);

        start_frame(1, 8'hA5);
        check_frame(1, 8'hA5, 0, 1);
        start_frame(2, 8'h07);
        check_frame(2, 8'h07, 0, 1);
        start_frame(2, 8'h03);
        check_frame(2, 8'h03, 1, 1);
        start_frame(3, 8'hFF);
        check_frame(3, 8'hFF, -1, 2);
        repeat (3) @(negedge clk);

        data_a[0] = 8'h55;
        valid_a[0] = 1'b1;
        @(negedge clk);
        data_a[0] = 8'h0F;
        check_frame(0, 8'h55, -1, 1);
        @(negedge clk);
        valid_a[0] = 1'b0;
        check("b2b_start", tx_a[0], 0);
        check("b2b_busy", busy_a[0], 1);
        check_frame(0, 8'h0F, -1, 1);
        repeat (3) @(negedge clk);

        start_frame(0, 8'hAA);
        repeat (4 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
        check("pre_clear_busy", busy_a[0], 1);
        rst = 1'b1;
        data_a[0] = 8'h11;
        valid_a[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid_a[0] = 1'b0;
        check("clr_tx", tx_a[0], 1);
        check("clr_busy", busy_a[0], 0);
        check("clr_clrn", clrn_a[0], 0);
        check("clr_en", en_a[0], 0);
        check("clr_done", done_a[0], 0);
        done_hits = 0;
        for (int c = 0; c < 40; c++) begin
            xtick_a[0] = (c % 3 == 0);
            if (done_a[0] || busy_a[0] || !tx_a[0]) done_hits++;
            @(negedge clk);
        end
        xtick_a[0] = 1'b0;
        check("idle_quiet", done_hits, 0);

        start_frame(0, 8'h3C);
        fork
            check_frame(0, 8'h3C, -1, 1);
            begin
                repeat (100) @(negedge clk);
                data_a[0] = 8'h00;
                valid_a[0] = 1'b1;
                @(negedge clk);
                valid_a[0] = 1'b0;
                repeat (200) @(negedge clk);
                valid_a[0] = 1'b1;
                repeat (3) @(negedge clk);
                valid_a[0] = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("post_busy", busy_a[0], 0);
        check("post_tx", tx_a[0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
